// File: rtl/uart_cmd_parser.sv
// Turns the UART receive byte stream into register-file write/read strobes
// and returns read data to the UART transmitter.
module uart_cmd_parser #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  parity_error,
    input  logic                  framing_error,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  busy,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic [7:0]            DROP_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'hBB);
    localparam logic [7:0]            WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wrData_q, wrData_d;
    logic [DATA_WIDTH-1:0]   txData_q, txData_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              dropCnt_q, dropCnt_d;
    logic                    wrEn_q, wrEn_d;
    logic                    rdEn_q, rdEn_d;
    logic                    txVld_q, txVld_d;
    logic                    drop;
    logic                    rxBad;
    logic                    rxGood;

    assign rxBad  = RX_D_VLD & (parity_error | framing_error);
    assign rxGood = RX_D_VLD & ~(parity_error | framing_error);

    // cnt_q holds (wait cycle - 1): the RdEn cycle is wait cycle 1, so the
    // last chance for RdData_Valid is when cnt_q equals TIMEOUT-1.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wrData_d = wrData_q;
        txData_d = txData_q;
        cnt_d    = cnt_q;
        wrEn_d   = 1'b0;
        rdEn_d   = 1'b0;
        txVld_d  = 1'b0;
        drop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxBad) begin
                    drop = 1'b1;
                end else if (rxGood) begin
                    if (RX_P_DATA == OP_WRITE) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == OP_READ) begin
                        state_d = RD_ADDR;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (rxBad) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else if (rxGood) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rxBad) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else if (rxGood) begin
                    wrData_d = RX_P_DATA;
                    wrEn_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_ADDR: begin
                if (rxBad) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else if (rxGood) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rdEn_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RdData_Valid) begin
                    txData_d = RdData;
                    state_d  = TX_SEND;
                end else if (cnt_q == WAIT_LAST) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            TX_SEND: begin
                if (!busy) begin
                    txVld_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        dropCnt_d = (drop && (dropCnt_q != 8'hFF)) ? dropCnt_q + 8'd1 : dropCnt_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wrData_q  <= '0;
            txData_q  <= '0;
            cnt_q     <= 8'd0;
            dropCnt_q <= 8'd0;
            wrEn_q    <= 1'b0;
            rdEn_q    <= 1'b0;
            txVld_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wrData_q  <= wrData_d;
            txData_q  <= txData_d;
            cnt_q     <= cnt_d;
            dropCnt_q <= dropCnt_d;
            wrEn_q    <= wrEn_d;
            rdEn_q    <= rdEn_d;
            txVld_q   <= txVld_d;
        end
    end

    assign WrEn      = wrEn_q;
    assign RdEn      = rdEn_q;
    assign Address   = addr_q;
    assign WrData    = wrData_q;
    assign TX_P_DATA = txData_q;
    assign TX_D_VLD  = txVld_q;
    assign DROP_CNT  = dropCnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser, built with a 4-cycle read
// timeout so the timeout and exact-deadline cases stay short.
module tb_uart_cmd_parser;

    logic       CLK;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       parity_error;
    logic       framing_error;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic       busy;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic [7:0] DROP_CNT;

    int checkCount = 0;
    int errorCount = 0;
    int wrCount    = 0;
    int rdCount    = 0;
    int txCount    = 0;

    uart_cmd_parser #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8),
        .TIMEOUT   (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .busy         (busy),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .DROP_CNT     (DROP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Strobe counters let the bench catch extra or missing pulses.
    always @(negedge CLK) begin
        if (WrEn)     wrCount++;
        if (RdEn)     rdCount++;
        if (TX_D_VLD) txCount++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Called at a negedge; the byte is sampled on the next rising edge and the
    // task returns at the following negedge, where the result is visible.
    task automatic applyStimulus(input logic [7:0] b, input logic pe, input logic fe);
        RX_P_DATA     = b;
        RX_D_VLD      = 1'b1;
        parity_error  = pe;
        framing_error = fe;
        @(negedge CLK);
        RX_D_VLD      = 1'b0;
        parity_error  = 1'b0;
        framing_error = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_WrEn"},      32'(WrEn),      32'h0);
        checkOutput({tag, "_RdEn"},      32'(RdEn),      32'h0);
        checkOutput({tag, "_TX_D_VLD"},  32'(TX_D_VLD),  32'h0);
        checkOutput({tag, "_Address"},   32'(Address),   32'h0);
        checkOutput({tag, "_WrData"},    32'(WrData),    32'h0);
        checkOutput({tag, "_TX_P_DATA"}, 32'(TX_P_DATA), 32'h0);
        checkOutput({tag, "_DROP_CNT"},  32'(DROP_CNT),  32'h0);
    endtask

    initial begin
        RST           = 1'b0;
        RX_P_DATA     = 8'h00;
        RX_D_VLD      = 1'b0;
        parity_error  = 1'b0;
        framing_error = 1'b0;
        RdData        = 8'h00;
        RdData_Valid  = 1'b0;
        busy          = 1'b0;
        #2;
        checkResetState("reset");
        idle(2);
        RST = 1'b1;
        idle(1);

        // Write frame with slow byte spacing
        applyStimulus(8'hAA, 1'b0, 1'b0);
        idle(7);
        applyStimulus(8'h05, 1'b0, 1'b0);
        idle(7);
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("wr_WrEn",    32'(WrEn),    32'h1);
        checkOutput("wr_Address", 32'(Address), 32'h5);
        checkOutput("wr_WrData",  32'(WrData),  32'h3C);
        idle(1);
        checkOutput("wr_WrEn_one_cycle", 32'(WrEn),   32'h0);
        checkOutput("wr_WrData_hold",    32'(WrData), 32'h3C);
        checkOutput("wr_wrCount", 32'(wrCount), 32'd1);
        checkOutput("wr_rdCount", 32'(rdCount), 32'd0);
        checkOutput("wr_txCount", 32'(txCount), 32'd0);
        checkOutput("wr_DROP",    32'(DROP_CNT), 32'h0);

        // Read frame; RdData_Valid lands on wait cycle 4, the last allowed one
        applyStimulus(8'hBB, 1'b0, 1'b0);
        applyStimulus(8'h02, 1'b0, 1'b0);
        checkOutput("rd_RdEn",    32'(RdEn),    32'h1);
        checkOutput("rd_Address", 32'(Address), 32'h2);
        idle(3);
        RdData       = 8'h7E;
        RdData_Valid = 1'b1;
        idle(1);
        RdData_Valid = 1'b0;
        checkOutput("rd_TX_P_DATA",  32'(TX_P_DATA), 32'h7E);
        checkOutput("rd_TX_VLD_early", 32'(TX_D_VLD), 32'h0);
        idle(1);
        checkOutput("rd_TX_D_VLD", 32'(TX_D_VLD), 32'h1);
        idle(1);
        checkOutput("rd_TX_VLD_one_cycle", 32'(TX_D_VLD),  32'h0);
        checkOutput("rd_TX_P_DATA_hold",   32'(TX_P_DATA), 32'h7E);
        checkOutput("rd_rdCount", 32'(rdCount), 32'd1);
        checkOutput("rd_txCount", 32'(txCount), 32'd1);
        checkOutput("rd_DROP",    32'(DROP_CNT), 32'h0);

        // Read with the transmitter busy; bytes arriving meanwhile are ignored
        busy = 1'b1;
        applyStimulus(8'hBB, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        RdData       = 8'hA5;
        RdData_Valid = 1'b1;
        idle(1);
        RdData_Valid = 1'b0;
        repeat (4) begin
            applyStimulus(8'h12, 1'b0, 1'b0);
            idle(1);
        end
        checkOutput("busy_TX_D_VLD_low", 32'(TX_D_VLD), 32'h0);
        checkOutput("busy_txCount",      32'(txCount),  32'd1);
        checkOutput("busy_DROP",         32'(DROP_CNT), 32'h0);
        busy = 1'b0;
        idle(1);
        checkOutput("busy_TX_D_VLD",   32'(TX_D_VLD),  32'h1);
        checkOutput("busy_TX_P_DATA",  32'(TX_P_DATA), 32'hA5);
        idle(1);
        checkOutput("busy_txCount_after", 32'(txCount), 32'd2);

        // Bad bytes and unknown opcodes
        applyStimulus(8'hAA, 1'b0, 1'b0);
        applyStimulus(8'h05, 1'b1, 1'b0);
        checkOutput("err_parity_DROP", 32'(DROP_CNT), 32'h1);
        applyStimulus(8'h12, 1'b0, 1'b0);
        checkOutput("err_opcode_DROP", 32'(DROP_CNT), 32'h2);
        applyStimulus(8'hAA, 1'b0, 1'b1);
        checkOutput("err_framing_opcode_DROP", 32'(DROP_CNT), 32'h3);
        idle(1);
        checkOutput("err_wrCount", 32'(wrCount), 32'd1);

        // Back-to-back write then read, the read timing out
        applyStimulus(8'hAA, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        checkOutput("b2b_WrEn",    32'(WrEn),    32'h1);
        checkOutput("b2b_Address", 32'(Address), 32'hF);
        checkOutput("b2b_WrData",  32'(WrData),  32'hFF);
        applyStimulus(8'hBB, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        checkOutput("to_RdEn",    32'(RdEn),    32'h1);
        checkOutput("to_Address", 32'(Address), 32'h1);
        idle(3);
        checkOutput("to_DROP_not_early", 32'(DROP_CNT), 32'h3);
        idle(1);
        checkOutput("to_DROP", 32'(DROP_CNT), 32'h4);
        applyStimulus(8'h12, 1'b0, 1'b0);
        checkOutput("to_back_in_idle_DROP", 32'(DROP_CNT), 32'h5);
        checkOutput("to_txCount", 32'(txCount), 32'd2);
        checkOutput("to_rdCount", 32'(rdCount), 32'd3);

        // Saturation
        repeat (260) applyStimulus(8'h12, 1'b0, 1'b0);
        checkOutput("sat_DROP", 32'(DROP_CNT), 32'hFF);
        checkOutput("sat_wrCount", 32'(wrCount), 32'd2);

        // Reset mid-frame
        applyStimulus(8'hAA, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        checkOutput("rst_pre_Address", 32'(Address), 32'h3);
        RST = 1'b0;
        #1;
        checkResetState("rst_mid");
        @(negedge CLK);
        RST = 1'b1;
        applyStimulus(8'h55, 1'b0, 1'b0);
        checkOutput("rst_55_DROP", 32'(DROP_CNT), 32'h1);
        idle(2);
        checkOutput("rst_wrCount", 32'(wrCount), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
